mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares one 4:1 mux datapath among four requesters.
//   Drives the mux select pair S1/S0 and a one-hot grant vector, so exactly one
//   requester owns the shared output F at a time. Registered outputs, one clock.
//   Grant-hold limit prevents a requester from starving the others.
// PARAMETERS
//   MAX_HOLD  8  cycles an owner may keep the grant while others wait; 0 = no limit
//   HOLD_W    4  hold-counter width; MAX_HOLD must be < 2**HOLD_W
// PORTS
//   CLK    in   1  clock, rising edge
//   RST_N  in   1  synchronous reset, active-low
//   REQ    in   4  request per requester; REQ[0]->mux input A ... REQ[3]->D
//   GNT    out  4  one-hot grant, 0000 when idle
//   S1     out  1  mux select MSB (index of granted requester, bit 1)
//   S0     out  1  mux select LSB (index of granted requester, bit 0)
//   BUSY   out  1  1 while any grant is active
// BEHAVIOUR
//   - Reset (RST_N=0 at posedge): state IDLE, GNT=0000, S1=S0=0, BUSY=0,
//     priority pointer PTR=0, hold counter CNT=0. Overrides all else, incl. mid-grant.
//   - All outputs registered; REQ sampled only at rising CLK. Latency REQ->GNT = 1 cycle.
//   - Selection: first set REQ bit in rotating order PTR, PTR+1, PTR+2, PTR+3 (mod 4).
//   - States: IDLE, GRANT.
//   - IDLE: REQ=0000 -> stay. Any REQ -> GRANT; GNT=onehot(k), {S1,S0}=k, BUSY=1, CNT=1.
//   - GRANT, owner i, each edge:
//     * REQ[i]=0 (release): PTR<=i+1. If other REQ set -> grant next per rotation
//       from i+1 on same edge (no idle bubble), CNT=1. Else -> IDLE, GNT=0000, BUSY=0.
//     * REQ[i]=1, MAX_HOLD!=0, CNT==MAX_HOLD, another REQ set (preempt): PTR<=i+1,
//       grant next requester after i, CNT=1.
//     * Otherwise hold grant; CNT increments, saturating at MAX_HOLD.
//   - Lone owner with no competitors is never preempted, regardless of CNT.
//   - In IDLE, S1/S0 hold last granted index (keeps mux stable); GNT=0000 is authoritative.
//   - Invariants: GNT one-hot or zero; BUSY == |GNT; when BUSY, {S1,S0} == index of GNT.
//   - Fairness: with MAX_HOLD=N>0, a held request is granted within 3*N cycles.
//   - Simultaneous release + new requests: rotation from i+1 applies; the releasing
//     requester re-asserting on the same edge is considered last.
// TESTING
//   1 Reset: REQ=1111, RST_N=0 two cycles -> GNT=0000, S1S0=00, BUSY=0; RST_N=1 ->
//     next edge GNT=0001, S1S0=00, BUSY=1.
//   2 Single: REQ=0100 from IDLE -> next edge GNT=0100, S1S0=10; REQ=0000 -> next
//     edge GNT=0000, BUSY=0, S1S0 stays 10.
//   3 Rotation: MAX_HOLD=8, REQ=1111 held -> owners 0,1,2,3,0, each exactly 8 cycles,
//     S1S0 stepping 00,01,10,11,00.
//   4 Handoff: owner 1, REQ=1010 -> REQ=1000 -> next edge GNT=1000, S1S0=11, BUSY never 0.
//   5 Lone holder: REQ=0010 held 20 cycles, MAX_HOLD=8 -> GNT=0010 throughout; then
//     REQ=0011 with CNT saturated -> next edge GNT=0001.
//   6 Mid-grant reset / no limit: MAX_HOLD=0, REQ=1111 -> owner 0 held 50 cycles;
//     RST_N=0 one cycle -> GNT=0000, PTR=0; release -> GNT=0001 again.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that drives the select pair and one-hot grant of a shared 4:1 mux.
// Owners are preempted after MAX_HOLD cycles only when another requester is waiting.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic       S1,
  output logic       S0,
  output logic       BUSY
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state;
  logic [3:0]        gnt;
  logic [1:0]        sel;
  logic              busy;
  logic [1:0]        ptr;
  logic [HOLD_W-1:0] cnt;

  logic [1:0]        start;
  logic [3:0]        cand;
  logic              found;
  logic [1:0]        next_idx;
  logic [1:0]        idx;
  logic              at_limit;
  logic              cnt_sat;

  // While granted, the search starts after the owner and excludes it,
  // so the current owner is always considered last.
  always_comb begin
    start    = (state == GRANT) ? sel + 2'd1 : ptr;
    cand     = REQ;
    if (state == GRANT)
      cand[sel] = 1'b0;
    found    = 1'b0;
    next_idx = '0;
    idx      = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && cand[idx]) begin
        found    = 1'b1;
        next_idx = idx;
      end
    end
  end

  always_comb begin
    at_limit = (MAX_HOLD != 0) && (cnt == HOLD_W'(MAX_HOLD));
    cnt_sat  = (MAX_HOLD == 0) ? (cnt == '1) : (cnt == HOLD_W'(MAX_HOLD));
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      busy  <= 1'b0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= GRANT;
            gnt   <= 4'b0001 << next_idx;
            sel   <= next_idx;
            busy  <= 1'b1;
            cnt   <= HOLD_W'(1);
          end
        end
        GRANT: begin
          if (!REQ[sel]) begin
            ptr <= sel + 2'd1;
            if (found) begin
              gnt <= 4'b0001 << next_idx;
              sel <= next_idx;
              cnt <= HOLD_W'(1);
            end else begin
              state <= IDLE;
              gnt   <= '0;
              busy  <= 1'b0;
              cnt   <= '0;
            end
          end else if (at_limit && found) begin
            ptr <= sel + 2'd1;
            gnt <= 4'b0001 << next_idx;
            sel <= next_idx;
            cnt <= HOLD_W'(1);
          end else if (!cnt_sat) begin
            cnt <= cnt + HOLD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign GNT  = gnt;
  assign S1   = sel[1];
  assign S0   = sel[0];
  assign BUSY = busy;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: one instance with an 8-cycle hold limit,
// one with no limit.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n8, rst_n0;
  logic [3:0] req8, req0;
  logic [3:0] gnt8, gnt0;
  logic       s1_8, s0_8, busy8;
  logic       s1_0, s0_0, busy0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  mux4_rr_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut8 (
    .CLK(clk), .RST_N(rst_n8), .REQ(req8),
    .GNT(gnt8), .S1(s1_8), .S0(s0_8), .BUSY(busy8)
  );

  mux4_rr_arbiter #(.MAX_HOLD(0), .HOLD_W(4)) dut0 (
    .CLK(clk), .RST_N(rst_n0), .REQ(req0),
    .GNT(gnt0), .S1(s1_0), .S0(s0_0), .BUSY(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect8(input string tag, input logic [3:0] g, input logic [1:0] s, input logic b);
    check({tag, ".gnt"}, 32'(gnt8), 32'(g));
    check({tag, ".sel"}, 32'({s1_8, s0_8}), 32'(s));
    check({tag, ".busy"}, 32'(busy8), 32'(b));
  endtask

  initial begin
    rst_n8 = 1'b0; rst_n0 = 1'b0;
    req8 = 4'b1111; req0 = 4'b0000;

    // Reset held two cycles with all requests asserted
    step(); step();
    expect8("rst", 4'b0000, 2'b00, 1'b0);
    rst_n8 = 1'b1;
    step();
    expect8("rst_rel", 4'b0001, 2'b00, 1'b1);

    // Single requester from idle, then release
    req8 = 4'b0000;
    step();
    expect8("idle", 4'b0000, 2'b00, 1'b0);
    req8 = 4'b0100;
    step();
    expect8("single", 4'b0100, 2'b10, 1'b1);
    req8 = 4'b0000;
    step();
    expect8("single_rel", 4'b0000, 2'b10, 1'b0);

    // Full rotation, 8 cycles per owner
    rst_n8 = 1'b0;
    step();
    rst_n8 = 1'b1;
    req8 = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      for (int c = 0; c < 8; c++) begin
        step();
        expect8($sformatf("rot%0d_%0d", o, c), 4'b0001 << (o % 4), 2'(o % 4), 1'b1);
      end
    end

    // Handoff from owner 1 to owner 3 without an idle cycle
    rst_n8 = 1'b0;
    req8 = 4'b0000;
    step();
    rst_n8 = 1'b1;
    req8 = 4'b0010;
    step();
    expect8("ho_own1", 4'b0010, 2'b01, 1'b1);
    req8 = 4'b1010;
    step();
    expect8("ho_hold", 4'b0010, 2'b01, 1'b1);
    req8 = 4'b1000;
    step();
    expect8("ho_next", 4'b1000, 2'b11, 1'b1);

    // Lone holder is never preempted; competitor wins once count saturated
    rst_n8 = 1'b0;
    req8 = 4'b0000;
    step();
    rst_n8 = 1'b1;
    req8 = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      step();
      check($sformatf("lone_%0d", c), 32'(gnt8), 32'(4'b0010));
    end
    req8 = 4'b0011;
    step();
    expect8("lone_pre", 4'b0001, 2'b00, 1'b1);

    // No-limit instance: long hold, mid-grant reset, regrant from pointer 0
    rst_n0 = 1'b1;
    req0 = 4'b1111;
    for (int c = 0; c < 50; c++) begin
      step();
      check($sformatf("nolim_%0d", c), 32'(gnt0), 32'(4'b0001));
    end
    rst_n0 = 1'b0;
    step();
    check("mid_rst.gnt", 32'(gnt0), 32'(4'b0000));
    check("mid_rst.sel", 32'({s1_0, s0_0}), 32'(2'b00));
    check("mid_rst.busy", 32'(busy0), 32'(1'b0));
    rst_n0 = 1'b1;
    step();
    check("mid_rel.gnt", 32'(gnt0), 32'(4'b0001));
    check("mid_rel.busy", 32'(busy0), 32'(1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
